uart_tx_param: RTL

Parametrised UART transmitter, successor to the fixed 8N1 transmitter. It serialises one data word per frame onto txd: a start bit, DATA_BITS data bits LSB first, an optional parity bit, then 1 or 2 stop bits. Upstream logic hands it words through a valid/ready handshake, and it reports frame completion with a one-cycle pulse. It sits between command/response logic and the board UART pin.

---
 rtl/uart_tx_param.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Every bit lasts BAUD_DIV = CLK_FREQ_HZ/BAUD clock cycles.
// Optional feature macro: UART_TX_FIFO_EN. When defined, a FIFO_DEPTH-word input FIFO
// sits in front of the serialiser; when undefined, the shift register is loaded directly
// from the handshake.
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   tx_data   word to send, sampled on tx_valid && tx_ready
//   tx_valid  tx_data is valid
//   tx_ready  a word can be accepted this cycle
//   txd       serial line, idles high
//   tx_busy   frame on the line or words pending
//   tx_done   one-cycle pulse after the last stop bit of a frame
`default_nettype none

module uart_tx_param #(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned BAUD        = 9600,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned BAUD_DIV = CLK_FREQ_HZ / BAUD;
    localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
    localparam int unsigned BIT_W    = $clog2(DATA_BITS);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Elaboration-time guard against illegal configurations
    if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_tx_param: illegal parameter set");
    end

    logic [2:0]           state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic                 par, par_nx;
    logic                 txd_nx, done_nx, busy_nx, ready_nx;

    logic                 src_valid;
    logic [DATA_BITS-1:0] src_data;
    logic                 bit_end, stop_last, load;

    assign bit_end   = (cnt == CNT_W'(BAUD_DIV - 1));
    assign stop_last = (state == ST_STOP) && bit_end && (bit_cnt == BIT_W'(STOP_BITS - 1));
    // A new word may start in IDLE or exactly as the last stop bit ends (zero-gap chaining)
    assign load      = src_valid && ((state == ST_IDLE) || stop_last);

`ifdef UART_TX_FIFO_EN
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;

    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr, wr_ptr;
    logic [FCNT_W-1:0]    fcnt, fcnt_nx;
    logic                 push;

    // tx_ready is !full, so a push into a full FIFO is refused even if a pop happens
    assign push      = tx_valid && tx_ready;
    assign src_valid = (fcnt != '0);
    assign src_data  = fifo_mem[rd_ptr];

    // Occupancy update; simultaneous push and pop leaves the count unchanged
    always_comb begin
        fcnt_nx = fcnt;
        case ({push, load})
            2'b10:   fcnt_nx = fcnt + FCNT_W'(1);
            2'b01:   fcnt_nx = fcnt - FCNT_W'(1);
            default: fcnt_nx = fcnt;
        endcase
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fcnt   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (load) rd_ptr <= rd_ptr + PTR_W'(1);
            fcnt <= fcnt_nx;
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= tx_data;
    end

    assign ready_nx = (fcnt_nx != FCNT_W'(FIFO_DEPTH));
    assign busy_nx  = (state_nx != ST_IDLE) || (fcnt_nx != '0);
`else
    assign src_valid = tx_valid && tx_ready;
    assign src_data  = tx_data;

    // Ready in IDLE and during the final cycle of the last stop bit
    assign ready_nx = (state_nx == ST_IDLE) ||
                      ((state_nx == ST_STOP) && (cnt_nx == CNT_W'(BAUD_DIV - 1)) &&
                       (bit_cnt_nx == BIT_W'(STOP_BITS - 1)));
    assign busy_nx  = (state_nx != ST_IDLE);
`endif

    // Next-state, next-line-value logic
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        par_nx     = par;
        txd_nx     = txd;
        done_nx    = 1'b0;

        if (state != ST_IDLE) begin
            cnt_nx = bit_end ? '0 : cnt + CNT_W'(1);
        end

        case (state)
            ST_IDLE: begin
                txd_nx = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_nx   = ST_DATA;
                    bit_cnt_nx = '0;
                    txd_nx     = shreg[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        bit_cnt_nx = '0;
                        if (PARITY != 0) begin
                            state_nx = ST_PARITY;
                            txd_nx   = par;
                        end else begin
                            state_nx = ST_STOP;
                            txd_nx   = 1'b1;
                        end
                    end else begin
                        bit_cnt_nx = bit_cnt + BIT_W'(1);
                        shreg_nx   = shreg >> 1;
                        txd_nx     = shreg[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_nx   = ST_STOP;
                    bit_cnt_nx = '0;
                    txd_nx     = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                        state_nx = ST_IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        bit_cnt_nx = bit_cnt + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                txd_nx   = 1'b1;
            end
        endcase

        // Loading a word overrides the stop-to-idle return; parity is fixed at load time
        if (load) begin
            state_nx = ST_START;
            cnt_nx   = '0;
            shreg_nx = src_data;
            par_nx   = (^src_data) ^ (PARITY == 1);
            txd_nx   = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            txd      <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            bit_cnt  <= bit_cnt_nx;
            shreg    <= shreg_nx;
            par      <= par_nx;
            txd      <= txd_nx;
            tx_ready <= ready_nx;
            tx_busy  <= busy_nx;
            tx_done  <= done_nx;
        end
    end

endmodule

`default_nettype wire
